// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer: turns RV32I byte/half accesses into word read-modify-write cycles.
// Latency: load 3, SW 2, SB/SH 4, reject 1 cycle(s); req_ready only in IDLE. Option: LSU_RANGE_CHECK_EN.
module load_store_unit #(
    parameter logic [31:0] BASE = 32'hFFFF0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        legal_f3;
    logic        misaligned;
    logic        range_bad;
    logic        reject;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] merged;

    assign accept = (state_q == S_IDLE) && req_valid;

`ifdef LSU_RANGE_CHECK_EN
    assign range_bad = (req_addr[31:16] != BASE[31:16]);
`else
    // Upper address bits alias into the window when the range check is off.
    logic addr_hi_unused;
    assign addr_hi_unused = ^req_addr[31:16];
    assign range_bad      = 1'b0;
`endif

    always_comb begin
        legal_f3 = 1'b0;
        if (req_store) begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                    || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        reject     = !legal_f3 || misaligned || range_bad;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            store_q     <= store_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (reject)                                state_d = S_ERR;
                    else if (req_store && req_funct3 == 3'b010) state_d = S_WRITE;
                    else                                        state_d = S_READ;
                end
            end
            S_READ:  state_d = S_MERGE;
            S_MERGE: state_d = store_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
        rsp_err   = (state_q == S_ERR);
        mem_we    = (state_q == S_WRITE);
    end

    always_comb begin
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lane_b      = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        merged      = mem_rdata;

        if (accept) begin
            addr_d   = req_addr[15:0];
            funct3_d = req_funct3;
            store_d  = req_store;
            wdata_d  = req_wdata[15:0];
            rdata_d  = '0;
            // The memory address/data registers only move for accesses that will touch memory.
            if (!reject) begin
                mem_addr_d = BASE | {16'h0, 2'b00, req_addr[15:2]};
                if (req_store && req_funct3 == 3'b010) mem_wdata_d = req_wdata;
            end
        end

        if (state_q == S_MERGE) begin
            if (store_q) begin
                if (funct3_q == 3'b000) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                else                    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
                mem_wdata_d = merged;
            end else begin
                case (funct3_q)
                    3'b000:  rdata_d = {{24{lane_b[7]}}, lane_b};
                    3'b001:  rdata_d = {{16{lane_h[15]}}, lane_h};
                    3'b010:  rdata_d = mem_rdata;
                    3'b100:  rdata_d = {24'h0, lane_b};
                    3'b101:  rdata_d = {16'h0, lane_h};
                    default: rdata_d = '0;
                endcase
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
